// File: rtl/usb_symbol_align.sv
// K28.5 comma aligner: hunts for a comma in the 10-bit shift window, then emits
// one aligned symbol every 10 clocks and re-aligns after repeated off-grid commas.
//
// state  | meaning
// -------+-------------------------------------------------------------
// HUNT   | no boundary known; first comma seen acquires lock
// LOCKED | boundary known; strobe on ph == 9, track off-grid commas
module usb_symbol_align #(
    parameter int ERR_MAX = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] Parin,
    output logic [9:0] Symout,
    output logic       sym_valid,
    output logic       is_comma,
    output logic       locked,
    output logic       realign
);

    typedef enum logic {HUNT, LOCKED} state_t;

    localparam logic [4:0] ERR_LIM = 5'(ERR_MAX);

    state_t     state, state_n;
    logic [3:0] ph, ph_n;
    logic [3:0] err, err_n;
    logic [9:0] sym_n;
    logic       valid_n, comma_n, realign_n;
    logic       match, boundary;
    logic [4:0] err_inc;

    assign match    = (Parin == 10'h17C) || (Parin == 10'h283);
    assign boundary = (state == LOCKED) && (ph == 4'd9);
    assign err_inc  = {1'b0, err} + 5'd1;

    always_comb begin
        state_n   = state;
        ph_n      = ph;
        err_n     = err;
        sym_n     = Symout;
        valid_n   = 1'b0;
        comma_n   = 1'b0;
        realign_n = 1'b0;
        case (state)
            HUNT: begin
                ph_n  = 4'd0;
                err_n = 4'd0;
                if (match) begin
                    state_n = LOCKED;
                    sym_n   = Parin;
                    valid_n = 1'b1;
                    comma_n = 1'b1;
                end
            end
            LOCKED: begin
                ph_n = (ph == 4'd9) ? 4'd0 : ph + 4'd1;
                if (boundary) begin
                    sym_n   = Parin;
                    valid_n = 1'b1;
                    comma_n = match;
                    if (match) err_n = 4'd0;
                end else if (match) begin
                    if (err_inc < ERR_LIM) begin
                        err_n = err_inc[3:0];
                    end else begin
                        // comma wins over the old grid: restart the period here
                        ph_n      = 4'd0;
                        err_n     = 4'd0;
                        sym_n     = Parin;
                        valid_n   = 1'b1;
                        comma_n   = 1'b1;
                        realign_n = 1'b1;
                    end
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            ph        <= 4'd0;
            err       <= 4'd0;
            Symout    <= 10'd0;
            sym_valid <= 1'b0;
            is_comma  <= 1'b0;
            locked    <= 1'b0;
            realign   <= 1'b0;
        end else begin
            state     <= state_n;
            ph        <= ph_n;
            err       <= err_n;
            Symout    <= sym_n;
            sym_valid <= valid_n;
            is_comma  <= comma_n;
            locked    <= (state_n == LOCKED);
            realign   <= realign_n;
        end
    end

endmodule

// File: tb/tb_usb_symbol_align.sv
// Directed bench for usb_symbol_align; two instances (ERR_MAX 2 and 1) share one
// serial bit stream so bit-slip behaviour of both thresholds is checked together.
module tb_usb_symbol_align;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] parin = 10'd0;

    logic [9:0] symout2, symout1;
    logic       valid2, comma2, locked2, realign2;
    logic       valid1, comma1, locked1, realign1;

    int tests = 0;
    int fails = 0;

    // per-symbol observations: e* = strobes in first 9 bit times, v/s/c/r = last bit time
    int         e2, e1, ra2, ra1;
    logic       v2, v1, c2, c1, r2, r1;
    logic [9:0] s2, s1;

    localparam logic [9:0] KM = 10'h17C;
    localparam logic [9:0] KP = 10'h283;
    localparam logic [9:0] D  = 10'h155;

    always #5 clk = ~clk;

    usb_symbol_align #(.ERR_MAX(2)) u_dut2 (
        .clk(clk), .rst(rst), .Parin(parin), .Symout(symout2),
        .sym_valid(valid2), .is_comma(comma2), .locked(locked2), .realign(realign2)
    );

    usb_symbol_align #(.ERR_MAX(1)) u_dut1 (
        .clk(clk), .rst(rst), .Parin(parin), .Symout(symout1),
        .sym_valid(valid1), .is_comma(comma1), .locked(locked1), .realign(realign1)
    );

    task automatic step(input logic b, input logic r);
        @(negedge clk);
        rst   = r;
        parin = {b, parin[9:1]};
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [9:0] p, input logic r);
        @(negedge clk);
        rst   = r;
        parin = p;
        @(posedge clk);
        #1;
    endtask

    // shift a symbol in bit a first; window equals the symbol on the last bit
    task automatic send_sym(input logic [9:0] s);
        e2 = 0; e1 = 0; ra2 = 0; ra1 = 0;
        for (int i = 0; i < 10; i++) begin
            step(s[i], 1'b0);
            ra2 += int'(realign2);
            ra1 += int'(realign1);
            if (i < 9) begin
                e2 += int'(valid2);
                e1 += int'(valid1);
            end
        end
        v2 = valid2; s2 = symout2; c2 = comma2; r2 = realign2;
        v1 = valid1; s1 = symout1; c1 = comma1; r1 = realign1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) hold(KM, 1'b1);
        tests++; if (symout2 !== 10'd0) begin fails++; $display("FAIL reset_symout got %h exp 000", symout2); end
        tests++; if ({valid2, comma2, locked2, realign2} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b exp 0000", {valid2, comma2, locked2, realign2}); end
        tests++; if ({valid1, locked1} !== 2'b0) begin fails++; $display("FAIL reset_flags_em1 got %b exp 00", {valid1, locked1}); end
        hold(10'h0AB, 1'b0);
        tests++; if ({valid2, locked2} !== 2'b0) begin fails++; $display("FAIL post_reset_noncomma got %b exp 00", {valid2, locked2}); end
    endtask

    task automatic test_acquire_rdm();
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        tests++; if ({valid2, locked2} !== 2'b0) begin fails++; $display("FAIL rdm_prefix got %b exp 00", {valid2, locked2}); end
        send_sym(KM);
        tests++; if (e2 !== 0) begin fails++; $display("FAIL rdm_early got %0d exp 0", e2); end
        tests++; if ({v2, c2, locked2, s2} !== {3'b111, KM}) begin fails++; $display("FAIL rdm_lock got v%b c%b l%b %h exp v1 c1 l1 17c", v2, c2, locked2, s2); end
        for (int k = 0; k < 3; k++) begin
            send_sym(D);
            tests++; if ({e2, v2, c2, s2} !== {32'd0, 2'b10, D}) begin fails++; $display("FAIL rdm_data%0d got e%0d v%b c%b %h exp e0 v1 c0 155", k, e2, v2, c2, s2); end
        end
        send_sym(KM);
        tests++; if ({e2, v2, c2, r2} !== {32'd0, 3'b110}) begin fails++; $display("FAIL rdm_comma2 got e%0d v%b c%b r%b exp e0 v1 c1 r0", e2, v2, c2, r2); end
    endtask

    task automatic test_acquire_rdp();
        logic [9:0] seq [8];
        seq = '{D, D, D, KM, D, D, D, KP};
        step(1'b0, 1'b1);
        tests++; if ({valid2, locked2, symout2} !== {2'b00, 10'd0}) begin fails++; $display("FAIL rdp_reset got v%b l%b %h exp v0 l0 000", valid2, locked2, symout2); end
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        send_sym(KP);
        tests++; if ({e2, v2, c2, locked2, s2} !== {32'd0, 3'b111, KP}) begin fails++; $display("FAIL rdp_lock got e%0d v%b c%b l%b %h exp e0 v1 c1 l1 283", e2, v2, c2, locked2, s2); end
        for (int k = 0; k < 8; k++) begin
            send_sym(seq[k]);
            tests++; if ({e2, v2, c2, s2, ra2} !== {32'd0, 1'b1, seq[k] != D, seq[k], 32'd0}) begin fails++; $display("FAIL rdp_alt%0d got e%0d v%b c%b %h ra%0d exp e0 v1 c%b %h ra0", k, e2, v2, c2, s2, ra2, seq[k] != D, seq[k]); end
        end
    endtask

    task automatic test_bit_slip();
        step(1'b0, 1'b0);
        tests++; if ({valid2, valid1} !== 2'b00) begin fails++; $display("FAIL slip_extra got %b exp 00", {valid2, valid1}); end
        send_sym(KM);
        tests++; if ({e2, v2, r2} !== {32'd1, 2'b00}) begin fails++; $display("FAIL slip_first_em2 got e%0d v%b r%b exp e1 v0 r0", e2, v2, r2); end
        tests++; if ({e1, v1, c1, r1, s1} !== {32'd1, 3'b111, KM}) begin fails++; $display("FAIL slip_first_em1 got e%0d v%b c%b r%b %h exp e1 v1 c1 r1 17c", e1, v1, c1, r1, s1); end
        for (int k = 0; k < 3; k++) begin
            send_sym(D);
            tests++; if ({e2, v2, ra2} !== {32'd1, 1'b0, 32'd0}) begin fails++; $display("FAIL slip_old_grid%0d got e%0d v%b ra%0d exp e1 v0 ra0", k, e2, v2, ra2); end
            tests++; if ({e1, v1, c1, s1} !== {32'd0, 2'b10, D}) begin fails++; $display("FAIL slip_em1_data%0d got e%0d v%b c%b %h exp e0 v1 c0 155", k, e1, v1, c1, s1); end
        end
        send_sym(KM);
        tests++; if ({e2, v2, c2, r2, s2} !== {32'd1, 3'b111, KM}) begin fails++; $display("FAIL slip_realign_em2 got e%0d v%b c%b r%b %h exp e1 v1 c1 r1 17c", e2, v2, c2, r2, s2); end
        tests++; if ({e1, v1, c1, r1} !== {32'd0, 3'b110}) begin fails++; $display("FAIL slip_aligned_em1 got e%0d v%b c%b r%b exp e0 v1 c1 r0", e1, v1, c1, r1); end
        for (int k = 0; k < 3; k++) begin
            send_sym(D);
            tests++; if ({e2, v2, c2, s2, ra2} !== {32'd0, 2'b10, D, 32'd0}) begin fails++; $display("FAIL slip_new_grid%0d got e%0d v%b c%b %h ra%0d exp e0 v1 c0 155 ra0", k, e2, v2, c2, s2, ra2); end
        end
    endtask

    task automatic test_mid_reset();
        send_sym(KM); send_sym(D); send_sym(D);
        for (int i = 0; i < 9; i++) step(D[i], 1'b0);
        step(D[9], 1'b1);
        tests++; if ({valid2, locked2, symout2} !== {2'b00, 10'd0}) begin fails++; $display("FAIL midrst_edge got v%b l%b %h exp v0 l0 000", valid2, locked2, symout2); end
        tests++; if ({valid1, locked1} !== 2'b00) begin fails++; $display("FAIL midrst_edge_em1 got %b exp 00", {valid1, locked1}); end
        send_sym(D);
        tests++; if ({e2, v2, locked2} !== {32'd0, 2'b00}) begin fails++; $display("FAIL midrst_hunt got e%0d v%b l%b exp e0 v0 l0", e2, v2, locked2); end
        send_sym(KM);
        tests++; if ({e2, v2, c2, locked2, s2} !== {32'd0, 3'b111, KM}) begin fails++; $display("FAIL midrst_relock got e%0d v%b c%b l%b %h exp e0 v1 c1 l1 17c", e2, v2, c2, locked2, s2); end
        send_sym(D);
        tests++; if ({e2, v2, c2, s2} !== {32'd0, 2'b10, D}) begin fails++; $display("FAIL midrst_data got e%0d v%b c%b %h exp e0 v1 c0 155", e2, v2, c2, s2); end
    endtask

    initial begin
        test_reset();
        test_acquire_rdm();
        test_acquire_rdp();
        test_bit_slip();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
